endzone_monitor: RTL and testbench

- Parametrised, runtime-programmable endzone detector with registered hit pipeline and dwell/win state machine.
- Holds a table of NUM_ZONES rectangles, written via a config port (replaces fixed per-map constants).
- Samples the player position once per frame and reports which zone the player occupies.
- Raises a one-cycle win pulse after the player stays DWELL_FRAMES consecutive samples in the same zone; sits between the maze game logic and the score/map-advance controller.

---
 rtl/endzone_pkg.sv | 22 ++
 rtl/endzone_hit.sv | 24 ++
 rtl/endzone_monitor.sv | 159 +++++++++++++++
 tb/tb_endzone_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/endzone_pkg.sv
// rtl/endzone_pkg.sv - shared types for the endzone monitor
`timescale 1ns/1ps
package endzone_pkg;

  // Table fields are stored at this width; the monitor zero-extends narrower coordinates.
  localparam int ZONE_COORD_W = 16;

  typedef struct packed {
    logic                    enable;
    logic [ZONE_COORD_W-1:0] rowstart;
    logic [ZONE_COORD_W-1:0] colstart;
    logic [ZONE_COORD_W-1:0] height;
    logic [ZONE_COORD_W-1:0] width;
  } zone_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    WON   = 2'd2
  } monitor_state_e;

endpackage

// File: rtl/endzone_hit.sv
// rtl/endzone_hit.sv - combinational single-rectangle hit test
`timescale 1ns/1ps
module endzone_hit
  import endzone_pkg::*;
(
  input  zone_entry_t             entry_i,
  input  logic [ZONE_COORD_W-1:0] row_i,
  input  logic [ZONE_COORD_W-1:0] col_i,
  output logic                    hit_o
);

  // One extra bit keeps rectangles touching the coordinate maximum from wrapping.
  logic [ZONE_COORD_W:0] row_end;
  logic [ZONE_COORD_W:0] col_end;

  assign row_end = {1'b0, entry_i.rowstart} + {1'b0, entry_i.height};
  assign col_end = {1'b0, entry_i.colstart} + {1'b0, entry_i.width};

  assign hit_o = entry_i.enable
               && (|entry_i.height) && (|entry_i.width)
               && (row_i >= entry_i.rowstart) && ({1'b0, row_i} < row_end)
               && (col_i >= entry_i.colstart) && ({1'b0, col_i} < col_end);

endmodule

// File: rtl/endzone_monitor.sv
// rtl/endzone_monitor.sv - programmable endzone detector with hit pipeline and dwell/win FSM
`timescale 1ns/1ps
module endzone_monitor
  import endzone_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int COORD_W      = 10,
  parameter int DWELL_FRAMES = 30,
  parameter int CNT_W        = $clog2(DWELL_FRAMES + 1),
  parameter int IDX_W        = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_enable,
  input  logic [COORD_W-1:0] cfg_rowstart,
  input  logic [COORD_W-1:0] cfg_colstart,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic               sample_valid,
  input  logic [COORD_W-1:0] player_row,
  input  logic [COORD_W-1:0] player_col,
  input  logic               rearm,
  output logic               in_zone,
  output logic [IDX_W-1:0]   zone_id,
  output logic [CNT_W-1:0]   dwell_count,
  output logic               win,
  output logic               won
);

  localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  zone_entry_t              table_q [NUM_ZONES];
  zone_entry_t              new_entry;
  logic [NUM_ZONES-1:0]     hit_comb;
  logic [NUM_ZONES-1:0]     hit_q;
  logic                     s1_valid_q;
  logic [ZONE_COORD_W-1:0]  row_ext;
  logic [ZONE_COORD_W-1:0]  col_ext;

  logic                     any_hit;
  logic [IDX_W-1:0]         enc_idx;
  logic                     in_zone_q, in_zone_d;
  logic [IDX_W-1:0]         zone_id_q, zone_id_d;
  monitor_state_e           state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     win_q, win_d;

  assign new_entry = '{enable:   cfg_enable,
                       rowstart: ZONE_COORD_W'(cfg_rowstart),
                       colstart: ZONE_COORD_W'(cfg_colstart),
                       height:   ZONE_COORD_W'(cfg_height),
                       width:    ZONE_COORD_W'(cfg_width)};
  assign row_ext = ZONE_COORD_W'(player_row);
  assign col_ext = ZONE_COORD_W'(player_col);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ZONES; i++) begin
      if (reset) begin
        table_q[i] <= '0;
      end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        table_q[i] <= new_entry;
      end
    end
  end

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_hit
    endzone_hit u_hit (
      .entry_i (table_q[g]),
      .row_i   (row_ext),
      .col_i   (col_ext),
      .hit_o   (hit_comb[g])
    );
  end

  // S1: the hit vector sees the table as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      hit_q      <= sample_valid ? hit_comb : hit_q;
      s1_valid_q <= sample_valid;
    end
  end

  always_comb begin
    any_hit = 1'b0;
    enc_idx = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        any_hit = 1'b1;
        enc_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= 1'b0;
      in_zone_q <= 1'b0;
      zone_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      in_zone_q <= in_zone_d;
      zone_id_q <= zone_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = 1'b0;
    in_zone_d = s1_valid_q ? any_hit : in_zone_q;
    zone_id_d = s1_valid_q ? enc_idx : zone_id_q;
    // rearm outranks a coincident sample, which is then not counted.
    if (state_q == WON) begin
      if (rearm) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (s1_valid_q) begin
      if (!any_hit) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (state_q == DWELL && enc_idx == zone_id_q) begin
        if (cnt_q + CNT_ONE == DWELL_CNT) begin
          state_d = WON;
          cnt_d   = DWELL_CNT;
          win_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (DWELL_FRAMES == 1) begin
        state_d = WON;
        cnt_d   = DWELL_CNT;
        win_d   = 1'b1;
      end else begin
        state_d = DWELL;
        cnt_d   = CNT_ONE;
      end
    end
  end

  always_comb begin
    in_zone     = in_zone_q;
    zone_id     = zone_id_q;
    dwell_count = cnt_q;
    win         = win_q;
    won         = (state_q == WON);
  end

endmodule

// File: tb/tb_endzone_monitor.sv
// tb/tb_endzone_monitor.sv - scoreboard bench for endzone_monitor
`timescale 1ns/1ps
module tb_endzone_monitor;

  localparam int NZ = 4;
  localparam int CW = 10;
  localparam int DF = 3;
  localparam int IW = 2;
  localparam int KW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_rowstart = '0;
  logic [CW-1:0] cfg_colstart = '0;
  logic [CW-1:0] cfg_height = '0;
  logic [CW-1:0] cfg_width = '0;
  logic          sample_valid = 1'b0;
  logic [CW-1:0] player_row = '0;
  logic [CW-1:0] player_col = '0;
  logic          rearm = 1'b0;
  logic          in_zone;
  logic [IW-1:0] zone_id;
  logic [KW-1:0] dwell_count;
  logic          win;
  logic          won;

  typedef struct packed {
    logic          iz;
    logic [IW-1:0] id;
    logic [KW-1:0] cnt;
    logic          w;
    logic          wn;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] vpipe = 2'b00;
  int         checks = 0;
  int         errors = 0;
  int         win_seen = 0;

  endzone_monitor #(.NUM_ZONES(NZ), .COORD_W(CW), .DWELL_FRAMES(DF)) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable),
    .cfg_rowstart(cfg_rowstart), .cfg_colstart(cfg_colstart),
    .cfg_height(cfg_height), .cfg_width(cfg_width),
    .sample_valid(sample_valid), .player_row(player_row), .player_col(player_col),
    .rearm(rearm),
    .in_zone(in_zone), .zone_id(zone_id), .dwell_count(dwell_count),
    .win(win), .won(won)
  );

  always #5 clk = ~clk;

  // Stimulus-side delay line: a sample's response is due two edges after it was driven.
  always @(posedge clk) vpipe <= reset ? 2'b00 : {vpipe[0], sample_valid};

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (win) win_seen++;
    if (!reset && vpipe[1]) begin
      checks++;
      a = {in_zone, zone_id, dwell_count, win, won};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got iz=%0d id=%0d cnt=%0d win=%0d won=%0d, no sample pending",
                 a.iz, a.id, a.cnt, a.w, a.wn);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL sample_response: got iz=%0d id=%0d cnt=%0d win=%0d won=%0d, required iz=%0d id=%0d cnt=%0d win=%0d won=%0d",
                   a.iz, a.id, a.cnt, a.w, a.wn, e.iz, e.id, e.cnt, e.w, e.wn);
        end
      end
    end
  end

  function automatic exp_t mk(bit iz, int id, int cnt, bit w, bit wn);
    exp_t e;
    e.iz  = iz;
    e.id  = IW'(id);
    e.cnt = KW'(cnt);
    e.w   = w;
    e.wn  = wn;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic prog(int idx, bit en, int rs, int cs, int h, int w);
    cfg_we       = 1'b1;
    cfg_idx      = IW'(idx);
    cfg_enable   = en;
    cfg_rowstart = CW'(rs);
    cfg_colstart = CW'(cs);
    cfg_height   = CW'(h);
    cfg_width    = CW'(w);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(int r, int c, bit push, exp_t e);
    sample_valid = 1'b1;
    player_row   = CW'(r);
    player_col   = CW'(c);
    if (push) exp_q.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_zero(string name);
    check(name, int'({in_zone, zone_id, dwell_count, win, won}), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    reset = 1'b0;
    @(negedge clk);

    send(5, 5, 1, mk(0, 0, 0, 0, 0));
    drain();

    prog(0, 1, 0, 0, 75, 75);
    send(74, 74, 1, mk(1, 0, 1, 0, 0));
    send(75, 74, 1, mk(0, 0, 0, 0, 0));
    drain();

    prog(1, 1, 405, 565, 75, 75);
    prog(2, 1, 420, 580, 100, 100);
    send(450, 600, 1, mk(1, 1, 1, 0, 0));
    send(0, 0, 1, mk(1, 0, 1, 0, 0));
    send(500, 500, 1, mk(0, 0, 0, 0, 0));
    drain();

    send(10, 10, 1, mk(1, 0, 1, 0, 0));
    send(10, 10, 1, mk(1, 0, 2, 0, 0));
    send(10, 10, 1, mk(1, 0, 3, 1, 1));
    send(10, 10, 1, mk(1, 0, 3, 0, 1));
    send(460, 600, 1, mk(1, 1, 3, 0, 1));
    send(500, 500, 1, mk(0, 0, 3, 0, 1));
    drain();
    check("win_pulses_first", win_seen, 1);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_count", int'(dwell_count), 0);
    check("rearm_won", int'(won), 0);

    send(1, 1, 1, mk(1, 0, 1, 0, 0));
    send(2, 2, 1, mk(1, 0, 2, 0, 0));
    send(450, 600, 1, mk(1, 1, 1, 0, 0));
    send(500, 500, 1, mk(0, 0, 0, 0, 0));
    drain();

    send(10, 10, 1, mk(1, 0, 1, 0, 0));
    send(10, 10, 1, mk(1, 0, 2, 0, 0));
    send(10, 10, 1, mk(1, 0, 3, 1, 1));
    drain();
    send(20, 20, 1, mk(1, 0, 0, 0, 0));
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    drain();
    check("win_pulses_second", win_seen, 2);

    prog(3, 1, 1000, 1000, 23, 23);
    send(1022, 1022, 1, mk(1, 3, 1, 0, 0));
    send(1023, 1023, 1, mk(0, 0, 0, 0, 0));
    drain();

    cfg_we = 1'b1; cfg_idx = '0; cfg_enable = 1'b0;
    cfg_rowstart = '0; cfg_colstart = '0; cfg_height = '0; cfg_width = '0;
    send(5, 5, 1, mk(1, 0, 1, 0, 0));
    cfg_we = 1'b0;
    send(5, 5, 1, mk(0, 0, 0, 0, 0));
    drain();

    prog(0, 1, 0, 0, 75, 75);
    send(1, 1, 1, mk(1, 0, 1, 0, 0));
    send(2, 2, 1, mk(1, 0, 2, 0, 0));
    drain();
    check("dwell_before_reset", int'(dwell_count), 2);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_dwell");
    @(negedge clk);
    reset = 1'b0;

    prog(0, 1, 0, 0, 75, 75);
    send(3, 3, 0, mk(0, 0, 0, 0, 0));
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("reset_mid_pipe");
    reset = 1'b0;
    @(negedge clk);
    check_zero("inflight_discarded");
    check("table_cleared", int'(dut.table_q[0].enable), 0);

    prog(0, 1, 0, 0, 75, 75);
    send(3, 3, 1, mk(1, 0, 1, 0, 0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
